// File: rtl/stream_pkg.sv
// stream_pkg: shared states, framing constants and helpers for the stream deframer/framer pair.
package stream_pkg;
   typedef enum logic [1:0] {S_CNT, S_DATA, S_DONE} deframer_state_t;
   localparam int CNT_BYTES = 4;
   function automatic int bytes_per_word(input int width);
      return width / 8;
   endfunction
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-entry output register feeding a din/write/full port.
module stream_out_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             full,
   output logic [WIDTH-1:0] dout,
   output logic             word_valid,
   output logic             write
);
   logic [WIDTH-1:0] dout_q, dout_d;
   logic word_valid_q, word_valid_d;
   always_comb begin
      write = word_valid_q & ~full;
      dout_d = load ? load_data : dout_q;
      word_valid_d = load | (word_valid_q & full);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
         word_valid_q <= 1'b0;
      end else begin
         dout_q <= dout_d;
         word_valid_q <= word_valid_d;
      end
   end
   assign dout = dout_q;
   assign word_valid = word_valid_q;
endmodule

// File: rtl/stream_byte_deframer.sv
// stream_byte_deframer: host bytes (LE signed count, then MSB-first words) to a kernel din/write/full port.
// Define DEFRAMER_WORD_CNT_EN to add the words_out/bursts_out counters.
module stream_byte_deframer
   import stream_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] dout,
   output logic             write,
   input  logic             full,
   output logic             active,
   output logic             proto_err
`ifdef DEFRAMER_WORD_CNT_EN
   ,
   output logic [31:0]      words_out,
   output logic [15:0]      bursts_out
`endif
);
   localparam logic [2:0] LAST_W = 3'(bytes_per_word(WIDTH) - 1);
   localparam logic [2:0] LAST_C = 3'(CNT_BYTES - 1);
   deframer_state_t state_q, state_d;
   logic [2:0] byte_idx_q, byte_idx_d;
   logic [CNT_W-9:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_next, remaining_q, remaining_d;
   logic [WIDTH-1:0] word_q, word_d, word_next;
   logic active_q, active_d, proto_err_q, proto_err_d;
   logic accept, last_byte, load, word_valid;
   always_comb begin
      state_d = state_q;
      byte_idx_d = byte_idx_q;
      remaining_d = remaining_q;
      word_d = word_q;
      load = 1'b0;
      last_byte = byte_idx_q == LAST_W;
      // only the byte that completes a word needs room in the output register
      in_ready = (state_q == S_CNT) | (state_q == S_DATA & (~last_byte | ~word_valid | write));
      accept = in_valid & in_ready;
      cnt_next = {in_byte, cnt_q};
      cnt_d = accept & state_q == S_CNT ? cnt_next[CNT_W-1:8] : cnt_q;
      word_next = (word_q << 8) | WIDTH'(in_byte);
      if (accept & state_q == S_CNT) begin
         byte_idx_d = byte_idx_q + 3'd1;
         if (byte_idx_q == LAST_C) begin
            byte_idx_d = '0;
            remaining_d = cnt_next;
            state_d = cnt_next[CNT_W-1] ? S_DONE : (|cnt_next ? S_DATA : S_CNT);
         end
      end
      if (accept & state_q == S_DATA) begin
         word_d = word_next;
         byte_idx_d = last_byte ? '0 : byte_idx_q + 3'd1;
         if (last_byte) begin
            load = 1'b1;
            remaining_d = remaining_q - CNT_W'(1);
            state_d = remaining_q == CNT_W'(1) ? S_CNT : S_DATA;
         end
      end
      proto_err_d = proto_err_q | (state_q == S_DONE & in_valid);
      // evaluated on next-cycle values so active drops right after the final write
      active_d = ~(state_d == S_DONE & ~(load | (word_valid & full)));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CNT;
         byte_idx_q <= '0;
         cnt_q <= '0;
         remaining_q <= '0;
         word_q <= '0;
         active_q <= 1'b1;
         proto_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_idx_q <= byte_idx_d;
         cnt_q <= cnt_d;
         remaining_q <= remaining_d;
         word_q <= word_d;
         active_q <= active_d;
         proto_err_q <= proto_err_d;
      end
   end
   stream_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_data(word_next),
      .full(full),
      .dout(dout),
      .word_valid(word_valid),
      .write(write)
   );
   assign active = active_q;
   assign proto_err = proto_err_q;
`ifdef DEFRAMER_WORD_CNT_EN
   logic [31:0] words_q, words_d;
   logic [15:0] bursts_q, bursts_d;
   logic hdr_pos;
   always_comb begin
      hdr_pos = accept & state_q == S_CNT & byte_idx_q == LAST_C & ~cnt_next[CNT_W-1] & |cnt_next;
      words_d = words_q + 32'(write);
      bursts_d = bursts_q + 16'(hdr_pos);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         words_q <= '0;
         bursts_q <= '0;
      end else begin
         words_q <= words_d;
         bursts_q <= bursts_d;
      end
   end
   assign words_out = words_q;
   assign bursts_out = bursts_q;
`endif
endmodule

// File: tb/tb_stream_byte_deframer.sv
// tb_stream_byte_deframer: directed and randomized streams checked against a stream-parsing model.
module tb_stream_byte_deframer;
   logic clk = 0, rst = 1;
   logic [7:0] in_byte = 0;
   logic in_valid = 0, full = 0;
   logic in_ready, write, active, proto_err;
   logic [15:0] dout;
`ifdef DEFRAMER_WORD_CNT_EN
   logic [31:0] words_out;
   logic [15:0] bursts_out;
`endif
   int checks = 0, failures = 0;
   logic [7:0] stream[$];
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   time got_t[$];
   time t_inactive;
   int bursts_exp = 0, writes_seen = 0, drv_idx = -1, drv_last = -2, full_mode = 0;
   bit chk_en = 0, eos_acc = 0, perr_exp = 0;
   int stall_cnt[64];

   stream_byte_deframer dut (
      .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .dout(dout), .write(write), .full(full), .active(active), .proto_err(proto_err)
`ifdef DEFRAMER_WORD_CNT_EN
      , .words_out(words_out), .bursts_out(bursts_out)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endfunction

   // model: decode the byte stream into the words the kernel must receive
   function automatic void parse();
      int p = 0;
      int c;
      exp_q.delete();
      bursts_exp = 0;
      while (p + 4 <= stream.size()) begin
         c = {stream[p+3], stream[p+2], stream[p+1], stream[p]};
         p += 4;
         if (c < 0) break;
         if (c > 0) bursts_exp++;
         for (int k = 0; k < c && p + 2 <= stream.size(); k++) begin
            exp_q.push_back({stream[p], stream[p+1]});
            p += 2;
         end
      end
   endfunction

   function automatic void push_cnt(input int c);
      for (int k = 0; k < 4; k++) stream.push_back(8'(c >> (8 * k)));
   endfunction

   function automatic void push_word(input logic [15:0] w);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
   endfunction

   always @(posedge clk) begin
      #2;
      full = (full_mode == 2) || (full_mode == 1 && $urandom_range(0, 3) == 0);
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("active", active, !(eos_acc && exp_q.size() == 0));
         chk("proto_err", proto_err, perr_exp);
         if (eos_acc) chk("in_ready_done", in_ready, 0);
         if (write) begin
            if (exp_q.size() == 0) chk("spurious_write", write, 0);
            else begin
               got_q.push_back(dout);
               got_t.push_back($time);
               chk("dout", dout, exp_q.pop_front());
               writes_seen++;
            end
         end
         if (in_valid && eos_acc) perr_exp = 1;
         if (in_valid && in_ready && drv_idx == drv_last) eos_acc = 1;
      end
   end

   task automatic reset_dut();
      rst = 1;
      in_valid = 0;
      drv_idx = -1;
      full_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      got_q.delete();
      got_t.delete();
      eos_acc = 0;
      perr_exp = 0;
      writes_seen = 0;
      bursts_exp = 0;
      rst = 0;
   endtask

   task automatic send_stream(input int gap_pct, input bit has_eos);
      int n;
      drv_last = has_eos ? stream.size() - 1 : -2;
      for (int i = 0; i < stream.size(); i++) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 0;
            drv_idx = -1;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         drv_idx = i;
         in_byte = stream[i];
         in_valid = 1;
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
         end
         if (!in_ready) chk("accept_timeout", 1, 0);
         if (i < 64) stall_cnt[i] = n;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      drv_idx = -1;
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (active && n < 2000) begin
         n++;
         @(negedge clk);
      end
      t_inactive = $time;
      chk("drain", active, 0);
      chk("leftover", exp_q.size(), 0);
`ifdef DEFRAMER_WORD_CNT_EN
      chk("words_out", words_out, writes_seen);
      chk("bursts_out", bursts_out, bursts_exp);
`endif
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_dut();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_write", write, 0);
      chk("rst_dout", dout, 0);
      chk("rst_active", active, 1);
      chk("rst_proto_err", proto_err, 0);
      chk_en = 1;
      @(posedge clk);
      #1;

      stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      parse();
      send_stream(0, 1);
      wait_done();
      chk("t1_count", got_q.size(), 2);
      chk("t1_w0", got_q[0], 16'h1234);
      chk("t1_w1", got_q[1], 16'hABCD);
      chk("t1_gap", got_t[1] - got_t[0], 20);
      chk("t1_inactive", t_inactive - got_t[1], 40);

      reset_dut();
      parse();
      fork
         send_stream(0, 1);
         begin
            int n = 0;
            @(negedge clk);
            while (!(in_valid && in_byte == 8'h34) && n < 100) begin
               n++;
               @(negedge clk);
            end
            full_mode = 2;
            repeat (10) begin
               @(negedge clk);
               chk("t2_hold_dout", dout, 16'h1234);
               chk("t2_hold_nowrite", write, 0);
            end
            full_mode = 0;
         end
      join
      wait_done();
      for (int i = 0; i < 12; i++) chk($sformatf("t2_stall%0d", i), stall_cnt[i] != 0, i == 7);
      chk("t2_count", got_q.size(), 2);
      chk("t2_w0", got_q[0], 16'h1234);
      chk("t2_w1", got_q[1], 16'hABCD);

      reset_dut();
      stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h55, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      parse();
      send_stream(0, 1);
      wait_done();
      chk("t3_count", got_q.size(), 1);
      chk("t3_w0", got_q[0], 16'h55AA);

      reset_dut();
      stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11};
      parse();
      send_stream(0, 0);
      reset_dut();
      @(negedge clk);
      chk("t4_in_ready", in_ready, 1);
      chk("t4_write", write, 0);
      chk("t4_active", active, 1);
      @(posedge clk);
      #1;
      stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 8'h33, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      parse();
      send_stream(0, 1);
      wait_done();
      chk("t4_count", got_q.size(), 1);
      chk("t4_w0", got_q[0], 16'h2233);

      @(posedge clk);
      #1;
      in_byte = 8'h77;
      in_valid = 1;
      repeat (3) begin
         @(negedge clk);
         chk("t5_in_ready", in_ready, 0);
         chk("t5_write", write, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      repeat (3) @(negedge clk);
      chk("t5_perr_sticky", proto_err, 1);
      chk("t5_count", got_q.size(), 1);
      @(posedge clk);
      #1;

`ifdef DEFRAMER_WORD_CNT_EN
      reset_dut();
      stream.delete();
      for (int b = 0; b < 3; b++) begin
         push_cnt(5);
         for (int k = 0; k < 5; k++) push_word(16'($urandom));
      end
      push_cnt(-1);
      parse();
      send_stream(20, 1);
      wait_done();
      chk("t6_words", words_out, 15);
      chk("t6_bursts", bursts_out, 3);
`endif

      for (int r = 0; r < 25; r++) begin
         reset_dut();
         full_mode = 1;
         stream.delete();
         repeat ($urandom_range(1, 4)) begin
            int c = $urandom_range(0, 6);
            push_cnt(c);
            for (int k = 0; k < c; k++) push_word(16'($urandom));
         end
         push_cnt(-int'($urandom_range(1, 100000)));
         parse();
         send_stream(30, 1);
         wait_done();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
